// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter and
// a future receiver.
//   parity_mode_t : decoded parity selection
//   stop_bits_t   : decoded stop-bit selection
//   tx_state_t    : transmitter FSM states
//   OVERSAMPLE    : baud ticks per bit period
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_mode_t;

  typedef enum logic [1:0] {
    STOP_1   = 2'd0,
    STOP_1_5 = 2'd1,
    STOP_2   = 2'd2
  } stop_bits_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } tx_state_t;

  // Codes 5..7 are reserved and behave as "no parity".
  function automatic parity_mode_t decode_parity(input logic [2:0] mode);
    case (mode)
      3'd1:    return PAR_EVEN;
      3'd2:    return PAR_ODD;
      3'd3:    return PAR_MARK;
      3'd4:    return PAR_SPACE;
      default: return PAR_NONE;
    endcase
  endfunction

  // Code 3 is an alias for two stop bits.
  function automatic stop_bits_t decode_stop(input logic [1:0] sel);
    case (sel)
      2'd0:    return STOP_1;
      2'd1:    return STOP_1_5;
      default: return STOP_2;
    endcase
  endfunction

  // Index of the final tick of the stop period (tick count minus one).
  function automatic logic [4:0] stop_last_tick(input stop_bits_t sb);
    case (sb)
      STOP_1:   return 5'(OVERSAMPLE - 1);
      STOP_1_5: return 5'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
      default:  return 5'(2 * OVERSAMPLE - 1);
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo_with_clear.sv
// sync_fifo_with_clear: show-ahead synchronous FIFO with flush and level.
//   clk, rst_n : clock, synchronous active-low reset
//   i_clear    : flush all entries (wins over a simultaneous write/read)
//   i_wr_en    : push i_wr_data (ignored when full)
//   i_rd_en    : pop the head word (ignored when empty)
//   o_rd_data  : head word, valid whenever !o_empty
//   o_full, o_empty, o_level : occupancy status
module sync_fifo_with_clear
  import uart_pkg::*;
#(
  parameter int  WIDTH = 9,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             push;
  logic             pop;

  assign o_full    = (level_q == FULL_LEVEL);
  assign o_empty   = (level_q == '0);
  assign o_level   = level_q;
  assign o_rd_data = mem[rd_ptr_q];

  assign push = i_wr_en && !o_full && !i_clear;
  assign pop  = i_rd_en && !o_empty && !i_clear;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversample tick generator.
//   clk, rst_n : clock, synchronous active-low reset
//   i_restart  : reload the counter from i_div and suppress the tick
//   i_div      : clocks per tick minus one (0 = tick every clock)
//   o_tick     : one-cycle tick when the down-counter reaches zero
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_restart,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (i_restart || (count_q == '0)) begin
      count_q <= i_div;
    end else begin
      count_q <= count_q - DIV_W'(1);
    end
  end

  // Restart holds the phase, so the first tick of a new frame lands
  // exactly i_div+1 clocks after the restart is released.
  assign o_tick = !i_restart && (count_q == '0);

endmodule

// File: rtl/uart_tx_ext.sv
// uart_tx_ext: UART transmitter with TX FIFO, internal 16x baud generator,
// 5..DATA_MAX data bits, five parity modes, 1/1.5/2 stop bits, CTS flow
// control and break generation.
//   clk, rst_n          : clock, synchronous active-low reset
//   i_enable            : allow new frames to start
//   i_data_bits         : data bits per frame (clamped to 5..DATA_MAX)
//   i_parity_mode       : 0 none, 1 even, 2 odd, 3 mark, 4 space, 5-7 none
//   i_stop_bits         : 0 = 1, 1 = 1.5, 2/3 = 2 stop bits
//   i_baud_div          : clocks per oversample tick minus one
//   i_cts_en, i_cts_n   : CTS flow control (cts_n asynchronous, active low)
//   i_break             : hold the line low (priority over data)
//   i_fifo_wr_en/_data  : push a word, LSB transmitted first
//   i_fifo_clear        : flush the FIFO
//   i_overflow_clr      : clear the sticky overflow flag
//   o_fifo_full/_empty/_level, o_overflow_error : FIFO status
//   o_busy              : transmitter not idle
//   o_tx_done           : one-cycle pulse as each frame's stop period ends
//   o_uart_tx           : serial line, idle high
module uart_tx_ext
  import uart_pkg::*;
#(
  parameter int  FIFO_DEPTH = 16,
  parameter int  DATA_MAX   = 9,
  parameter int  DIV_W      = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_enable,
  input  logic [3:0]          i_data_bits,
  input  logic [2:0]          i_parity_mode,
  input  logic [1:0]          i_stop_bits,
  input  logic [DIV_W-1:0]    i_baud_div,
  input  logic                i_cts_en,
  input  logic                i_cts_n,
  input  logic                i_break,
  input  logic                i_fifo_wr_en,
  input  logic [DATA_MAX-1:0] i_fifo_wr_data,
  input  logic                i_fifo_clear,
  input  logic                i_overflow_clr,
  output logic                o_fifo_full,
  output logic                o_fifo_empty,
  output logic [LVL_W-1:0]    o_fifo_level,
  output logic                o_overflow_error,
  output logic                o_busy,
  output logic                o_tx_done,
  output logic                o_uart_tx
);

  localparam logic [3:0] MIN_BITS = 4'd5;
  localparam logic [3:0] MAX_BITS = 4'(DATA_MAX);
  localparam logic [4:0] BIT_LAST = 5'(OVERSAMPLE - 1);

  tx_state_t           state_q;
  tx_state_t           state_d;

  logic                cts_meta_q;
  logic                cts_sync_q;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    div_sel;
  logic                tick;
  logic                restart;
  logic [4:0]          tick_cnt_q;
  logic                unit_end;
  logic                stop_end;

  logic [DATA_MAX-1:0] shift_q;
  logic [3:0]          bit_idx_q;
  logic [3:0]          nbits_q;
  logic [3:0]          nbits_in;
  parity_mode_t        parity_q;
  logic [4:0]          stop_last_q;
  logic                par_acc_q;
  logic                guard_q;
  logic                parity_bit;

  logic                frame_go;
  logic                pop;
  logic [DATA_MAX-1:0] fifo_head;
  logic                overflow_q;

  sync_fifo_with_clear #(
    .WIDTH (DATA_MAX),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (i_fifo_clear),
    .i_wr_en   (i_fifo_wr_en),
    .i_wr_data (i_fifo_wr_data),
    .i_rd_en   (pop),
    .o_rd_data (fifo_head),
    .o_full    (o_fifo_full),
    .o_empty   (o_fifo_empty),
    .o_level   (o_fifo_level)
  );

  // The divisor is sampled while idle and frozen for the whole frame so a
  // mid-frame register write cannot change the bit period.
  assign restart = (state_q == ST_IDLE);
  assign div_sel = restart ? i_baud_div : div_q;

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (restart),
    .i_div     (div_sel),
    .o_tick    (tick)
  );

  assign unit_end = tick && (tick_cnt_q == BIT_LAST);
  assign stop_end = tick && (tick_cnt_q == stop_last_q);
  assign frame_go = i_enable && !o_fifo_empty && (!i_cts_en || !cts_sync_q);

  always_comb begin
    nbits_in = i_data_bits;
    if (i_data_bits < MIN_BITS) begin
      nbits_in = MIN_BITS;
    end else if (i_data_bits > MAX_BITS) begin
      nbits_in = MAX_BITS;
    end
  end

  always_comb begin
    case (parity_q)
      PAR_EVEN: parity_bit = par_acc_q;
      PAR_ODD:  parity_bit = !par_acc_q;
      PAR_MARK: parity_bit = 1'b1;
      default:  parity_bit = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_break) begin
          state_d = ST_BREAK;
        end else if (frame_go) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (unit_end) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (unit_end && (bit_idx_q == nbits_q - 4'd1)) begin
          state_d = (parity_q == PAR_NONE) ? ST_STOP : ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (unit_end) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (stop_end) begin
          state_d = ST_IDLE;
        end
      end
      ST_BREAK: begin
        if (guard_q && unit_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and the FIFO pop strobe.
  always_comb begin
    o_uart_tx = 1'b1;
    o_tx_done = 1'b0;
    o_busy    = (state_q != ST_IDLE);
    pop       = 1'b0;
    case (state_q)
      ST_IDLE:   pop       = !i_break && frame_go;
      ST_START:  o_uart_tx = 1'b0;
      ST_DATA:   o_uart_tx = shift_q[0];
      ST_PARITY: o_uart_tx = parity_bit;
      ST_STOP:   o_tx_done = stop_end;
      ST_BREAK:  o_uart_tx = guard_q;
      default:   o_uart_tx = 1'b1;
    endcase
  end

  // Datapath: CTS synchroniser, tick counter, frame shifter and latched config.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cts_meta_q  <= 1'b1;
      cts_sync_q  <= 1'b1;
      div_q       <= '0;
      tick_cnt_q  <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      nbits_q     <= MIN_BITS;
      parity_q    <= PAR_NONE;
      stop_last_q <= BIT_LAST;
      par_acc_q   <= 1'b0;
      guard_q     <= 1'b0;
    end else begin
      cts_meta_q <= i_cts_n;
      cts_sync_q <= cts_meta_q;

      if (restart) begin
        div_q <= i_baud_div;
      end

      // Every bit is 16 ticks except the stop period, so the counter wraps
      // at the end of each bit and only STOP counts beyond 15.
      if (state_q == ST_IDLE) begin
        tick_cnt_q <= '0;
      end else if (tick) begin
        if ((state_q == ST_STOP) ? stop_end : unit_end) begin
          tick_cnt_q <= '0;
        end else begin
          tick_cnt_q <= tick_cnt_q + 5'd1;
        end
      end

      if (pop) begin
        shift_q     <= fifo_head;
        bit_idx_q   <= '0;
        par_acc_q   <= 1'b0;
        nbits_q     <= nbits_in;
        parity_q    <= decode_parity(i_parity_mode);
        stop_last_q <= stop_last_tick(decode_stop(i_stop_bits));
      end else if ((state_q == ST_DATA) && unit_end) begin
        shift_q   <= shift_q >> 1;
        par_acc_q <= par_acc_q ^ shift_q[0];
        bit_idx_q <= bit_idx_q + 4'd1;
      end

      // After break release the low bit period is finished, then one full
      // bit period of high line is forced before returning to idle.
      if (state_q != ST_BREAK) begin
        guard_q <= 1'b0;
      end else if (!guard_q && unit_end && !i_break) begin
        guard_q <= 1'b1;
      end
    end
  end

  // Setting the overflow flag takes precedence over clearing it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (i_fifo_wr_en && o_fifo_full) begin
      overflow_q <= 1'b1;
    end else if (i_overflow_clr) begin
      overflow_q <= 1'b0;
    end
  end

  assign o_overflow_error = overflow_q;

endmodule

// File: tb/tb_uart_tx_ext.sv
// tb_uart_tx_ext: self-checking bench for uart_tx_ext.
module tb_uart_tx_ext;

  logic       clk;
  logic       rst_n;
  logic       i_enable;
  logic [3:0] i_data_bits;
  logic [2:0] i_parity_mode;
  logic [1:0] i_stop_bits;
  logic [15:0] i_baud_div;
  logic       i_cts_en;
  logic       i_cts_n;
  logic       i_break;
  logic       i_fifo_wr_en;
  logic [8:0] i_fifo_wr_data;
  logic       i_fifo_clear;
  logic       i_overflow_clr;
  logic       o_fifo_full;
  logic       o_fifo_empty;
  logic [4:0] o_fifo_level;
  logic       o_overflow_error;
  logic       o_busy;
  logic       o_tx_done;
  logic       o_uart_tx;

  int total;
  int bad;

  typedef struct {
    int         db;
    int         pm;
    int         sb;
    int         div;
    logic [8:0] data;
    int         exp_len;
    bit         exp_par;
  } vec_t;

  vec_t vecs[7];

  uart_tx_ext dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_enable         (i_enable),
    .i_data_bits      (i_data_bits),
    .i_parity_mode    (i_parity_mode),
    .i_stop_bits      (i_stop_bits),
    .i_baud_div       (i_baud_div),
    .i_cts_en         (i_cts_en),
    .i_cts_n          (i_cts_n),
    .i_break          (i_break),
    .i_fifo_wr_en     (i_fifo_wr_en),
    .i_fifo_wr_data   (i_fifo_wr_data),
    .i_fifo_clear     (i_fifo_clear),
    .i_overflow_clr   (i_overflow_clr),
    .o_fifo_full      (o_fifo_full),
    .o_fifo_empty     (o_fifo_empty),
    .o_fifo_level     (o_fifo_level),
    .o_overflow_error (o_overflow_error),
    .o_busy           (o_busy),
    .o_tx_done        (o_tx_done),
    .o_uart_tx        (o_uart_tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: frame shape computed directly from the line format.
  function automatic int nbits_of(input int db);
    return (db < 5) ? 5 : ((db > 9) ? 9 : db);
  endfunction

  function automatic bit par_on(input int pm);
    return (pm >= 1) && (pm <= 4);
  endfunction

  function automatic bit par_bit(input int pm, input int db, input logic [8:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < nbits_of(db); i++) ones += int'(d[i]);
    case (pm)
      1:       return bit'(ones % 2);
      2:       return bit'(1 - ones % 2);
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int stop_ticks(input int sb);
    return (sb == 0) ? 16 : ((sb == 1) ? 24 : 32);
  endfunction

  function automatic int frame_len(input int db, input int pm, input int sb, input int div);
    return (1 + nbits_of(db) + int'(par_on(pm))) * 16 * (div + 1) + stop_ticks(sb) * (div + 1);
  endfunction

  function automatic bit exp_level(input int db, input int pm, input int sb, input int div,
                                   input logic [8:0] d, input int t);
    int bl;
    int idx;
    bl  = 16 * (div + 1);
    idx = t / bl;
    if (idx == 0) return 1'b0;
    if (idx <= nbits_of(db)) return d[idx-1];
    if (par_on(pm) && idx == nbits_of(db) + 1) return par_bit(pm, db, d);
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushWord(input logic [8:0] d);
    i_fifo_wr_en   = 1'b1;
    i_fifo_wr_data = d;
    @(negedge clk);
    i_fifo_wr_en   = 1'b0;
  endtask

  task automatic applyStimulus(input int db, input int pm, input int sb, input int div, input logic [8:0] d);
    i_data_bits   = db[3:0];
    i_parity_mode = pm[2:0];
    i_stop_bits   = sb[1:0];
    i_baud_div    = div[15:0];
    pushWord(d);
  endtask

  task automatic waitLevel(input logic lvl, input int limit, output int waited);
    waited = 0;
    while (o_uart_tx !== lvl && waited < limit) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // Called on the first clock of a start bit; 8 bits at 16 clocks per bit.
  task automatic rxAfterStart(output logic [7:0] b);
    repeat (24) @(negedge clk);
    b[0] = o_uart_tx;
    for (int k = 1; k < 8; k++) begin
      repeat (16) @(negedge clk);
      b[k] = o_uart_tx;
    end
    repeat (16) @(negedge clk);
  endtask

  task automatic runFrame(input string name, input int db, input int pm, input int sb, input int div,
                          input logic [8:0] d, input int exp_len, input bit exp_par, input bit chk_par);
    int   done_t;
    int   mism;
    int   first_bad;
    int   bl;
    int   flen;
    logic par_seen;
    done_t    = -1;
    mism      = 0;
    first_bad = -1;
    par_seen  = 1'bx;
    bl        = 16 * (div + 1);
    flen      = frame_len(db, pm, sb, div);
    applyStimulus(db, pm, sb, div, d);
    checkOutput({name, "_pre_start_high"}, 32'(o_uart_tx), 1);
    @(negedge clk);
    checkOutput({name, "_start_low"}, 32'(o_uart_tx), 0);
    for (int t = 0; t < exp_len + 64; t++) begin
      if (t < flen && o_uart_tx !== exp_level(db, pm, sb, div, d, t)) begin
        mism++;
        if (first_bad < 0) first_bad = t;
      end
      if (chk_par && t == (1 + nbits_of(db)) * bl + bl / 2) par_seen = o_uart_tx;
      if (o_tx_done === 1'b1) begin
        done_t = t;
        break;
      end
      @(negedge clk);
    end
    checkOutput({name, "_frame_len"}, 32'(done_t + 1), 32'(exp_len));
    checkOutput({name, "_waveform_errors"}, 32'(mism), 0);
    if (mism != 0) $display("[TB] %s first wrong sample at clock %0d", name, first_bad);
    if (chk_par) checkOutput({name, "_parity_bit"}, 32'(par_seen), 32'(exp_par));
    @(negedge clk);
    checkOutput({name, "_idle_after"}, {29'd0, o_busy, o_tx_done, o_uart_tx}, 32'b001);
  endtask

  initial begin
    int         w;
    int         lows;
    int         highs;
    int         lat;
    int         db;
    int         pm;
    int         sb;
    int         dv;
    logic [8:0] d;
    logic [7:0] rx;

    total = 0;
    bad   = 0;

    vecs[0] = '{8, 0, 0, 0, 9'h055, 160, 1'b0};
    vecs[1] = '{7, 1, 2, 3, 9'h07F, 704, 1'b1};
    vecs[2] = '{7, 2, 2, 3, 9'h07F, 704, 1'b0};
    vecs[3] = '{9, 3, 1, 0, 9'h1A5, 200, 1'b1};
    vecs[4] = '{5, 4, 0, 1, 9'h1F3, 256, 1'b0};
    vecs[5] = '{3, 1, 0, 0, 9'h007, 128, 1'b1};
    vecs[6] = '{15, 6, 3, 0, 9'h1FF, 192, 1'b0};

    rst_n          = 1'b0;
    i_enable       = 1'b1;
    i_data_bits    = 4'd8;
    i_parity_mode  = 3'd0;
    i_stop_bits    = 2'd0;
    i_baud_div     = 16'd0;
    i_cts_en       = 1'b0;
    i_cts_n        = 1'b0;
    i_break        = 1'b0;
    i_fifo_wr_en   = 1'b0;
    i_fifo_wr_data = '0;
    i_fifo_clear   = 1'b0;
    i_overflow_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    checkOutput("reset_line", 32'(o_uart_tx), 1);
    checkOutput("reset_busy", 32'(o_busy), 0);
    checkOutput("reset_done", 32'(o_tx_done), 0);
    checkOutput("reset_overflow", 32'(o_overflow_error), 0);
    checkOutput("reset_empty", 32'(o_fifo_empty), 1);
    checkOutput("reset_full", 32'(o_fifo_full), 0);
    checkOutput("reset_level", 32'(o_fifo_level), 0);

    for (int v = 0; v < 7; v++) begin
      runFrame($sformatf("vec%0d", v), vecs[v].db, vecs[v].pm, vecs[v].sb, vecs[v].div,
               vecs[v].data, vecs[v].exp_len, vecs[v].exp_par, par_on(vecs[v].pm));
    end

    for (int r = 0; r < 8; r++) begin
      db = int'($urandom_range(3, 12));
      pm = int'($urandom_range(0, 7));
      sb = int'($urandom_range(0, 3));
      dv = int'($urandom_range(0, 2));
      d  = 9'($urandom);
      runFrame($sformatf("rand%0d", r), db, pm, sb, dv, d, frame_len(db, pm, sb, dv),
               par_bit(pm, db, d), par_on(pm));
    end

    // CTS flow control: words wait while CTS is deasserted.
    i_data_bits = 4'd8; i_parity_mode = 3'd0; i_stop_bits = 2'd0; i_baud_div = 16'd0;
    i_cts_en = 1'b1;
    i_cts_n  = 1'b1;
    repeat (3) @(negedge clk);
    pushWord(9'h011);
    pushWord(9'h022);
    pushWord(9'h033);
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      if (o_uart_tx !== 1'b1) lows++;
      @(negedge clk);
    end
    checkOutput("cts_held_line_high", 32'(lows), 0);
    checkOutput("cts_held_level", 32'(o_fifo_level), 3);
    i_cts_n = 1'b0;
    waitLevel(1'b0, 6, lat);
    checkOutput("cts_release_latency_ok", 32'(lat >= 1 && lat <= 4), 1);
    checkOutput("cts_level_after_pop", 32'(o_fifo_level), 2);
    repeat (50) @(negedge clk);
    i_cts_n = 1'b1;
    w = 0;
    while (o_tx_done !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    checkOutput("cts_frame_completes", 32'(w < 300), 1);
    lows = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_uart_tx !== 1'b1) lows++;
    end
    checkOutput("cts_next_frame_held", 32'(lows), 0);
    checkOutput("cts_level_held", 32'(o_fifo_level), 2);
    i_fifo_clear = 1'b1;
    @(negedge clk);
    i_fifo_clear = 1'b0;
    checkOutput("clear_empty", 32'(o_fifo_empty), 1);
    checkOutput("clear_level", 32'(o_fifo_level), 0);
    i_cts_en = 1'b0;
    i_cts_n  = 1'b0;

    // Overflow: 17 writes while disabled, extra words must be dropped.
    i_enable = 1'b0;
    for (int k = 0; k < 17; k++) pushWord((k < 16) ? 9'(8'hA0 + k) : 9'h03C);
    checkOutput("ovf_full", 32'(o_fifo_full), 1);
    checkOutput("ovf_level", 32'(o_fifo_level), 16);
    checkOutput("ovf_flag_set", 32'(o_overflow_error), 1);
    i_overflow_clr = 1'b1;
    pushWord(9'h0C3);
    i_overflow_clr = 1'b0;
    checkOutput("ovf_set_beats_clear", 32'(o_overflow_error), 1);
    i_overflow_clr = 1'b1;
    @(negedge clk);
    i_overflow_clr = 1'b0;
    checkOutput("ovf_flag_cleared", 32'(o_overflow_error), 0);
    checkOutput("ovf_level_kept", 32'(o_fifo_level), 16);
    i_enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      waitLevel(1'b0, 400, w);
      checkOutput($sformatf("ovf_rx%0d_started", k), 32'(w < 400), 1);
      rxAfterStart(rx);
      checkOutput($sformatf("ovf_rx%0d_data", k), 32'(rx), 32'(8'hA0 + k));
    end
    lows = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_uart_tx !== 1'b1) lows++;
    end
    checkOutput("ovf_extra_not_sent", 32'(lows), 0);
    checkOutput("ovf_drained_empty", 32'(o_fifo_empty), 1);

    // Break requested mid-frame: frame completes, break, guard, queued word.
    pushWord(9'h0FF);
    repeat (30) @(negedge clk);
    i_break = 1'b1;
    pushWord(9'h05A);
    w = 0;
    while (o_tx_done !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    checkOutput("brk_frame_completes", 32'(w < 300), 1);
    repeat (2) @(negedge clk);
    highs = 0;
    for (int k = 0; k < 100; k++) begin
      if (o_uart_tx !== 1'b0) highs++;
      @(negedge clk);
    end
    checkOutput("brk_line_low_while_held", 32'(highs), 0);
    checkOutput("brk_word_waits", 32'(o_fifo_level), 1);
    i_break = 1'b0;
    waitLevel(1'b1, 40, lows);
    checkOutput("brk_release_within_bit", 32'(lows <= 16), 1);
    waitLevel(1'b0, 100, highs);
    checkOutput("brk_guard_min_16", 32'(highs >= 16 && highs < 100), 1);
    rxAfterStart(rx);
    checkOutput("brk_queued_word", 32'(rx), 32'h5A);

    // Reset in the middle of a frame: line high at once, nothing resumes.
    repeat (20) @(negedge clk);
    pushWord(9'h000);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_line_high", 32'(o_uart_tx), 1);
    checkOutput("rst_mid_not_busy", 32'(o_busy), 0);
    rst_n = 1'b1;
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_uart_tx !== 1'b1) lows++;
    end
    checkOutput("rst_mid_no_resume", 32'(lows), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
